// File: rtl/wb_rr_arbiter.sv
// -----------------------------------------------------------------------------
// wb_rr_arbiter
// Round-robin arbiter sharing one pipelined Wishbone target port between
// N_ITR initiators. The grant is held for a whole bus cycle (CYC high) and
// is extended across cycles while the owner keeps LOCK asserted.
//
// Ports
//   clk_i, async_rst_i (async, active high), sync_rst_i (sync, active high)
//   itr_*_i      : per-initiator request signals, vectors sliced per initiator
//   itr_ack/err/rty_o : responses, routed to the current owner only
//   itr_stall_o  : owner sees tgt_stall_i, everyone else is stalled
//   itr_dat_o    : read data, broadcast to all initiators
//   tgt_*_o      : owner's request signals (all zero when nobody owns the bus)
//   tgt_*_i      : target responses
//   gnt_o        : registered one-hot0 grant
// -----------------------------------------------------------------------------
module wb_rr_arbiter #(
    parameter int N_ITR     = 4,
    parameter int ADR_WIDTH = 16,
    parameter int DAT_WIDTH = 16,
    parameter int SEL_WIDTH = 2
) (
    input  logic                           clk_i,
    input  logic                           async_rst_i,
    input  logic                           sync_rst_i,
    input  logic [N_ITR-1:0]               itr_cyc_i,
    input  logic [N_ITR-1:0]               itr_stb_i,
    input  logic [N_ITR-1:0]               itr_we_i,
    input  logic [N_ITR-1:0]               itr_lock_i,
    input  logic [N_ITR*SEL_WIDTH-1:0]     itr_sel_i,
    input  logic [N_ITR*ADR_WIDTH-1:0]     itr_adr_i,
    input  logic [N_ITR*DAT_WIDTH-1:0]     itr_dat_i,
    output logic [N_ITR-1:0]               itr_ack_o,
    output logic [N_ITR-1:0]               itr_err_o,
    output logic [N_ITR-1:0]               itr_rty_o,
    output logic [N_ITR-1:0]               itr_stall_o,
    output logic [DAT_WIDTH-1:0]           itr_dat_o,
    output logic                           tgt_cyc_o,
    output logic                           tgt_stb_o,
    output logic                           tgt_we_o,
    output logic                           tgt_lock_o,
    output logic [SEL_WIDTH-1:0]           tgt_sel_o,
    output logic [ADR_WIDTH-1:0]           tgt_adr_o,
    output logic [DAT_WIDTH-1:0]           tgt_dat_o,
    input  logic                           tgt_ack_i,
    input  logic                           tgt_err_i,
    input  logic                           tgt_rty_i,
    input  logic                           tgt_stall_i,
    input  logic [DAT_WIDTH-1:0]           tgt_dat_i,
    output logic [N_ITR-1:0]               gnt_o
);

    // A single initiator still needs a 1-bit pointer register; it never moves.
    localparam int PTR_W = (N_ITR > 1) ? $clog2(N_ITR) : 1;

    logic [N_ITR-1:0]     r_gnt;
    logic [PTR_W-1:0]     r_ptr;
    logic [N_ITR-1:0]     w_gnt_next;
    logic [PTR_W-1:0]     w_ptr_next;
    logic                 w_owner_active;
    logic [SEL_WIDTH-1:0] w_sel;
    logic [ADR_WIDTH-1:0] w_adr;
    logic [DAT_WIDTH-1:0] w_dat;

    // LOCK alone keeps the bus owned, so a locked owner between cycles is
    // never preempted even though its CYC is low.
    assign w_owner_active = |(r_gnt & (itr_cyc_i | itr_lock_i));

    // Next grant: hold an active owner, otherwise rotate from the pointer.
    always_comb begin
        int idx;
        logic found;
        w_gnt_next = '0;
        w_ptr_next = r_ptr;
        found      = 1'b0;
        idx        = 0;
        if (w_owner_active) begin
            w_gnt_next = r_gnt;
        end else begin
            for (int i = 0; i < N_ITR; i++) begin
                idx = (int'(r_ptr) + i) % N_ITR;
                if (!found && itr_cyc_i[idx]) begin
                    found             = 1'b1;
                    w_gnt_next[idx]   = 1'b1;
                    w_ptr_next        = PTR_W'((idx + 1) % N_ITR);
                end else begin
                    found = found;
                end
            end
        end
    end

    // Grant and round-robin pointer registers.
    always_ff @(posedge clk_i or posedge async_rst_i) begin
        if (async_rst_i) begin
            r_gnt <= '0;
            r_ptr <= '0;
        end else if (sync_rst_i) begin
            r_gnt <= '0;
            r_ptr <= '0;
        end else begin
            r_gnt <= w_gnt_next;
            r_ptr <= w_ptr_next;
        end
    end

    // Vector request mux: the grant is one-hot0, so AND-OR selection yields
    // the owner's slice, or all zeros when the bus is free.
    always_comb begin
        w_sel = '0;
        w_adr = '0;
        w_dat = '0;
        for (int i = 0; i < N_ITR; i++) begin
            w_sel = w_sel | (itr_sel_i[i*SEL_WIDTH +: SEL_WIDTH] & {SEL_WIDTH{r_gnt[i]}});
            w_adr = w_adr | (itr_adr_i[i*ADR_WIDTH +: ADR_WIDTH] & {ADR_WIDTH{r_gnt[i]}});
            w_dat = w_dat | (itr_dat_i[i*DAT_WIDTH +: DAT_WIDTH] & {DAT_WIDTH{r_gnt[i]}});
        end
    end

    assign tgt_cyc_o  = |(r_gnt & itr_cyc_i);
    assign tgt_stb_o  = |(r_gnt & itr_stb_i);
    assign tgt_we_o   = |(r_gnt & itr_we_i);
    // LOCK is only meaningful to the target inside a bus cycle.
    assign tgt_lock_o = |(r_gnt & itr_lock_i & itr_cyc_i);
    assign tgt_sel_o  = w_sel;
    assign tgt_adr_o  = w_adr;
    assign tgt_dat_o  = w_dat;

    // Responses go to the owner only; with no owner they are dropped.
    assign itr_ack_o   = r_gnt & {N_ITR{tgt_ack_i}};
    assign itr_err_o   = r_gnt & {N_ITR{tgt_err_i}};
    assign itr_rty_o   = r_gnt & {N_ITR{tgt_rty_i}};
    assign itr_stall_o = ~r_gnt | {N_ITR{tgt_stall_i}};
    assign itr_dat_o   = tgt_dat_i;

    assign gnt_o = r_gnt;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_rr_arbiter
// Table-driven bench for wb_rr_arbiter (N_ITR=4, 16-bit address/data).
// Each table row is one clock cycle: inputs driven just after the rising
// edge, expectations queued, then popped and compared on the falling edge.
// Hand-written sequences cover reset entry, mux/response routing and an
// asynchronous reset in the middle of a cycle.
// -----------------------------------------------------------------------------
module tb_wb_rr_arbiter;

    logic        clk_i = 1'b0;
    logic        async_rst_i;
    logic        sync_rst_i;
    logic [3:0]  itr_cyc_i, itr_stb_i, itr_we_i, itr_lock_i;
    logic [7:0]  itr_sel_i;
    logic [63:0] itr_adr_i, itr_dat_i;
    logic [3:0]  itr_ack_o, itr_err_o, itr_rty_o, itr_stall_o;
    logic [15:0] itr_dat_o;
    logic        tgt_cyc_o, tgt_stb_o, tgt_we_o, tgt_lock_o;
    logic [1:0]  tgt_sel_o;
    logic [15:0] tgt_adr_o, tgt_dat_o;
    logic        tgt_ack_i, tgt_err_i, tgt_rty_i, tgt_stall_i;
    logic [15:0] tgt_dat_i;
    logic [3:0]  gnt_o;

    wb_rr_arbiter #(.N_ITR(4), .ADR_WIDTH(16), .DAT_WIDTH(16), .SEL_WIDTH(2)) dut (
        .clk_i(clk_i), .async_rst_i(async_rst_i), .sync_rst_i(sync_rst_i),
        .itr_cyc_i(itr_cyc_i), .itr_stb_i(itr_stb_i), .itr_we_i(itr_we_i),
        .itr_lock_i(itr_lock_i), .itr_sel_i(itr_sel_i), .itr_adr_i(itr_adr_i),
        .itr_dat_i(itr_dat_i), .itr_ack_o(itr_ack_o), .itr_err_o(itr_err_o),
        .itr_rty_o(itr_rty_o), .itr_stall_o(itr_stall_o), .itr_dat_o(itr_dat_o),
        .tgt_cyc_o(tgt_cyc_o), .tgt_stb_o(tgt_stb_o), .tgt_we_o(tgt_we_o),
        .tgt_lock_o(tgt_lock_o), .tgt_sel_o(tgt_sel_o), .tgt_adr_o(tgt_adr_o),
        .tgt_dat_o(tgt_dat_o), .tgt_ack_i(tgt_ack_i), .tgt_err_i(tgt_err_i),
        .tgt_rty_i(tgt_rty_i), .tgt_stall_i(tgt_stall_i), .tgt_dat_i(tgt_dat_i),
        .gnt_o(gnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [3:0]  cyc, stb, lock;
        logic        ack, err, stall, srst;
        logic [15:0] adr2;
        logic [3:0]  e_gnt;
        logic        e_cyc;
        logic [3:0]  e_ack, e_err, e_stall;
        logic [15:0] e_adr;
    } vec_t;

    localparam int NV = 39;
    vec_t tbl [NV];
    vec_t sb_q [$];
    int   n_chk  = 0;
    int   n_pass = 0;

    function automatic vec_t mk(input logic [3:0] cyc, input logic [3:0] stb,
                                input logic [3:0] lock, input logic ack, input logic err,
                                input logic stall, input logic srst, input logic [15:0] adr2,
                                input logic [3:0] e_gnt, input logic e_cyc,
                                input logic [3:0] e_ack, input logic [3:0] e_err,
                                input logic [3:0] e_stall, input logic [15:0] e_adr);
        vec_t v;
        v.cyc = cyc; v.stb = stb; v.lock = lock; v.ack = ack; v.err = err;
        v.stall = stall; v.srst = srst; v.adr2 = adr2; v.e_gnt = e_gnt;
        v.e_cyc = e_cyc; v.e_ack = e_ack; v.e_err = e_err; v.e_stall = e_stall;
        v.e_adr = e_adr;
        return v;
    endfunction

    // Write data of the initiator a grant pattern selects (0 when none).
    function automatic logic [15:0] owner_dat(input logic [3:0] g);
        case (g)
            4'b0001: return 16'hD000;
            4'b0010: return 16'hD001;
            4'b0100: return 16'hD002;
            4'b1000: return 16'hD003;
            default: return 16'h0000;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        itr_cyc_i   = v.cyc;
        itr_stb_i   = v.stb;
        itr_lock_i  = v.lock;
        tgt_ack_i   = v.ack;
        tgt_err_i   = v.err;
        tgt_stall_i = v.stall;
        sync_rst_i  = v.srst;
        itr_adr_i   = {16'hF003, v.adr2, 16'hF001, 16'hF000};
    endtask

    initial begin
        // Cycle-by-cycle table, starting one edge after reset release.
        // cyc stb lock ack err stall srst adr2 | gnt tcyc ack err stall adr
        // rotation 0,1,2,3,0 with single-access cycles
        tbl[0]  = mk(4'b1111, 4'b0001, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0020, 4'b0001, 1'b1, 4'b0001, 4'b0000, 4'b1110, 16'hF000);
        tbl[1]  = mk(4'b1110, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0020, 4'b0001, 1'b0, 4'b0000, 4'b0000, 4'b1110, 16'hF000);
        tbl[2]  = mk(4'b1111, 4'b0010, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0020, 4'b0010, 1'b1, 4'b0010, 4'b0010, 4'b1101, 16'hF001);
        tbl[3]  = mk(4'b1101, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0020, 4'b0010, 1'b0, 4'b0000, 4'b0000, 4'b1101, 16'hF001);
        tbl[4]  = mk(4'b1111, 4'b0100, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0020, 4'b0100, 1'b1, 4'b0100, 4'b0000, 4'b1011, 16'h0020);
        tbl[5]  = mk(4'b1011, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0020, 4'b0100, 1'b0, 4'b0000, 4'b0000, 4'b1011, 16'h0020);
        tbl[6]  = mk(4'b1111, 4'b1000, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0020, 4'b1000, 1'b1, 4'b1000, 4'b0000, 4'b0111, 16'hF003);
        tbl[7]  = mk(4'b0111, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0020, 4'b1000, 1'b0, 4'b0000, 4'b0000, 4'b0111, 16'hF003);
        tbl[8]  = mk(4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0020, 4'b0001, 1'b1, 4'b0000, 4'b0000, 4'b1110, 16'hF000);
        tbl[9]  = mk(4'b0100, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0020, 4'b0001, 1'b0, 4'b0000, 4'b0000, 4'b1110, 16'hF000);
        // initiator 2 pipelined burst, two stalled cycles, three acks
        tbl[10] = mk(4'b0100, 4'b0100, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0010, 4'b0100, 1'b1, 4'b0000, 4'b0000, 4'b1111, 16'h0010);
        tbl[11] = mk(4'b0100, 4'b0100, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0010, 4'b0100, 1'b1, 4'b0000, 4'b0000, 4'b1111, 16'h0010);
        tbl[12] = mk(4'b0100, 4'b0100, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0010, 4'b0100, 1'b1, 4'b0000, 4'b0000, 4'b1011, 16'h0010);
        tbl[13] = mk(4'b0100, 4'b0100, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0011, 4'b0100, 1'b1, 4'b0100, 4'b0000, 4'b1011, 16'h0011);
        tbl[14] = mk(4'b0100, 4'b0100, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0012, 4'b0100, 1'b1, 4'b0100, 4'b0000, 4'b1011, 16'h0012);
        tbl[15] = mk(4'b0100, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0012, 4'b0100, 1'b1, 4'b0100, 4'b0000, 4'b1011, 16'h0012);
        // initiator 1 locked across cycles while initiator 3 waits
        tbl[16] = mk(4'b0010, 4'b0000, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0012, 4'b0100, 1'b0, 4'b0000, 4'b0000, 4'b1011, 16'h0012);
        tbl[17] = mk(4'b0010, 4'b0010, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0012, 4'b0010, 1'b1, 4'b0010, 4'b0000, 4'b1101, 16'hF001);
        tbl[18] = mk(4'b1000, 4'b0000, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0012, 4'b0010, 1'b0, 4'b0000, 4'b0000, 4'b1101, 16'hF001);
        tbl[19] = mk(4'b1000, 4'b0000, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0012, 4'b0010, 1'b0, 4'b0000, 4'b0000, 4'b1101, 16'hF001);
        tbl[20] = mk(4'b1000, 4'b0000, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0012, 4'b0010, 1'b0, 4'b0000, 4'b0000, 4'b1101, 16'hF001);
        tbl[21] = mk(4'b1010, 4'b0010, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0012, 4'b0010, 1'b1, 4'b0010, 4'b0000, 4'b1101, 16'hF001);
        tbl[22] = mk(4'b1000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0012, 4'b0010, 1'b0, 4'b0000, 4'b0000, 4'b1101, 16'hF001);
        tbl[23] = mk(4'b1000, 4'b1000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0012, 4'b1000, 1'b1, 4'b0000, 4'b0000, 4'b0111, 16'hF003);
        // owner 0 aborts with an ack outstanding; late ack goes to owner 1
        tbl[24] = mk(4'b0001, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0012, 4'b1000, 1'b0, 4'b0000, 4'b0000, 4'b0111, 16'hF003);
        tbl[25] = mk(4'b0011, 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0012, 4'b0001, 1'b1, 4'b0000, 4'b0000, 4'b1110, 16'hF000);
        tbl[26] = mk(4'b0010, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0012, 4'b0001, 1'b0, 4'b0000, 4'b0000, 4'b1110, 16'hF000);
        tbl[27] = mk(4'b0010, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0012, 4'b0010, 1'b1, 4'b0010, 4'b0000, 4'b1101, 16'hF001);
        tbl[28] = mk(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0012, 4'b0010, 1'b0, 4'b0000, 4'b0000, 4'b1101, 16'hF001);
        tbl[29] = mk(4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0012, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b1111, 16'h0000);
        // sync reset mid-cycle of owner 3, then pointer restart check
        tbl[30] = mk(4'b1000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0012, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b1111, 16'h0000);
        tbl[31] = mk(4'b1000, 4'b1000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0012, 4'b1000, 1'b1, 4'b0000, 4'b0000, 4'b0111, 16'hF003);
        tbl[32] = mk(4'b1000, 4'b1000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0012, 4'b1000, 1'b1, 4'b0000, 4'b0000, 4'b0111, 16'hF003);
        tbl[33] = mk(4'b1000, 4'b1000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0012, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b1111, 16'h0000);
        tbl[34] = mk(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0012, 4'b1000, 1'b0, 4'b0000, 4'b0000, 4'b0111, 16'hF003);
        tbl[35] = mk(4'b0010, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0012, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b1111, 16'h0000);
        tbl[36] = mk(4'b0010, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0012, 4'b0010, 1'b1, 4'b0000, 4'b0000, 4'b1101, 16'hF001);
        tbl[37] = mk(4'b1011, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0012, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b1111, 16'h0000);
        tbl[38] = mk(4'b1011, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0012, 4'b0001, 1'b1, 4'b0000, 4'b0000, 4'b1110, 16'hF000);

        // Static per-initiator attributes: we on odd initiators, sel = ~index.
        itr_we_i    = 4'b1010;
        itr_sel_i   = {2'b00, 2'b01, 2'b10, 2'b11};
        itr_dat_i   = {16'hD003, 16'hD002, 16'hD001, 16'hD000};
        itr_adr_i   = {16'hF003, 16'h0020, 16'hF001, 16'hF000};
        itr_cyc_i   = 4'b1111;
        itr_stb_i   = 4'b0000;
        itr_lock_i  = 4'b0000;
        tgt_ack_i   = 1'b0;
        tgt_err_i   = 1'b0;
        tgt_rty_i   = 1'b0;
        tgt_stall_i = 1'b0;
        tgt_dat_i   = 16'h5A5A;
        sync_rst_i  = 1'b0;
        async_rst_i = 1'b1;

        // Reset held with every initiator requesting.
        @(negedge clk_i);
        @(negedge clk_i);
        chk("rst gnt", 64'(gnt_o), 64'(4'b0000));
        chk("rst tgt_cyc", 64'(tgt_cyc_o), 64'(1'b0));
        chk("rst stall", 64'(itr_stall_o), 64'(4'b1111));
        async_rst_i = 1'b0;

        for (int i = 0; i < NV; i++) begin
            @(posedge clk_i);
            #1;
            drive(tbl[i]);
            sb_q.push_back(tbl[i]);
            @(negedge clk_i);
            if (sb_q.size() == 0) begin
                chk($sformatf("v%0d scoreboard empty", i), 64'(0), 64'(1));
            end else begin
                vec_t e;
                e = sb_q.pop_front();
                chk($sformatf("v%0d gnt", i), 64'(gnt_o), 64'(e.e_gnt));
                chk($sformatf("v%0d onehot0", i), 64'($countones(gnt_o) <= 1), 64'(1));
                chk($sformatf("v%0d tgt_cyc", i), 64'(tgt_cyc_o), 64'(e.e_cyc));
                chk($sformatf("v%0d ack", i), 64'(itr_ack_o), 64'(e.e_ack));
                chk($sformatf("v%0d err", i), 64'(itr_err_o), 64'(e.e_err));
                chk($sformatf("v%0d stall", i), 64'(itr_stall_o), 64'(e.e_stall));
                chk($sformatf("v%0d tgt_adr", i), 64'(tgt_adr_o), 64'(e.e_adr));
                chk($sformatf("v%0d tgt_dat", i), 64'(tgt_dat_o), 64'(owner_dat(e.e_gnt)));
            end
        end

        // Owner 0 holds the bus; check remaining request mux and responses.
        @(posedge clk_i);
        #1;
        itr_cyc_i   = 4'b0001;
        itr_stb_i   = 4'b0001;
        itr_lock_i  = 4'b0001;
        tgt_ack_i   = 1'b0;
        tgt_err_i   = 1'b0;
        tgt_rty_i   = 1'b1;
        tgt_dat_i   = 16'hBEEF;
        @(negedge clk_i);
        chk("mux gnt", 64'(gnt_o), 64'(4'b0001));
        chk("mux tgt_stb", 64'(tgt_stb_o), 64'(1'b1));
        chk("mux tgt_we", 64'(tgt_we_o), 64'(1'b0));
        chk("mux tgt_sel", 64'(tgt_sel_o), 64'(2'b11));
        chk("mux tgt_lock", 64'(tgt_lock_o), 64'(1'b1));
        chk("mux rty", 64'(itr_rty_o), 64'(4'b0001));
        chk("mux itr_dat", 64'(itr_dat_o), 64'(16'hBEEF));

        // Hand the bus to initiator 1 (odd: we=1, sel=2'b10) via rotation.
        @(posedge clk_i);
        #1;
        itr_cyc_i  = 4'b0010;
        itr_stb_i  = 4'b0010;
        itr_lock_i = 4'b0000;
        @(negedge clk_i);
        chk("hand gnt still 0", 64'(gnt_o), 64'(4'b0001));
        @(posedge clk_i);
        #1;
        @(negedge clk_i);
        chk("hand gnt 1", 64'(gnt_o), 64'(4'b0010));
        chk("hand tgt_we", 64'(tgt_we_o), 64'(1'b1));
        chk("hand tgt_sel", 64'(tgt_sel_o), 64'(2'b10));
        chk("hand tgt_lock no lock", 64'(tgt_lock_o), 64'(1'b0));
        chk("hand rty", 64'(itr_rty_o), 64'(4'b0010));

        // Asynchronous reset between edges clears the grant immediately.
        #1;
        async_rst_i = 1'b1;
        #1;
        chk("arst gnt", 64'(gnt_o), 64'(4'b0000));
        chk("arst tgt_cyc", 64'(tgt_cyc_o), 64'(1'b0));
        chk("arst stall", 64'(itr_stall_o), 64'(4'b1111));
        chk("arst rty dropped", 64'(itr_rty_o), 64'(4'b0000));
        @(negedge clk_i);
        async_rst_i = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/wb_rr_arbiter.md
Name: wb_rr_arbiter

Overview:
- Round-robin arbiter that shares one pipelined Wishbone target bus between N_ITR initiators.
- Sits between initiator ports and a single target port, which downstream can be a slave or a crossbar leg.
- Holds the grant for a complete bus cycle; LOCK extends ownership across back-to-back cycles.
- Muxes the owner's request signals to the target and routes the target's responses back to the owner only.

Parameters:
N_ITR, 4, number of initiators (2..16)
ADR_WIDTH, 16, address bus width
DAT_WIDTH, 16, data bus width
SEL_WIDTH, 2, number of select lines

Ports:
clk_i  in  1  module clock
async_rst_i  in  1  asynchronous reset, active high
sync_rst_i  in  1  synchronous reset, active high
itr_cyc_i  in  N_ITR  per-initiator bus cycle indicator
itr_stb_i  in  N_ITR  per-initiator access request
itr_we_i  in  N_ITR  per-initiator write enable
itr_lock_i  in  N_ITR  per-initiator lock
itr_sel_i  in  N_ITR*SEL_WIDTH  selects, initiator i at slice i
itr_adr_i  in  N_ITR*ADR_WIDTH  addresses, sliced
itr_dat_i  in  N_ITR*DAT_WIDTH  write data, sliced
itr_ack_o  out  N_ITR  acknowledge to owner
itr_err_o  out  N_ITR  error to owner
itr_rty_o  out  N_ITR  retry to owner
itr_stall_o  out  N_ITR  stall to each initiator
itr_dat_o  out  DAT_WIDTH  read data, broadcast to all initiators
tgt_cyc_o, tgt_stb_o, tgt_we_o, tgt_lock_o  out  1 each  muxed request signals
tgt_sel_o  out  SEL_WIDTH  muxed selects
tgt_adr_o  out  ADR_WIDTH  muxed address
tgt_dat_o  out  DAT_WIDTH  muxed write data
tgt_ack_i, tgt_err_i, tgt_rty_i, tgt_stall_i  in  1 each  target response signals
tgt_dat_i  in  DAT_WIDTH  read data from target
gnt_o  out  N_ITR  registered one-hot0 grant, for monitoring

Behaviour:
- Clocking and reset: async_rst_i is asynchronous, active high. sync_rst_i is synchronous. All state is on clk_i.
- State: gnt_reg (one-hot0, N_ITR bits) and ptr_reg (index of highest-priority initiator, $clog2(N_ITR) bits).
- Reset values: gnt_reg=0, ptr_reg=0. With gnt_reg=0:
  - all tgt_* request outputs are 0;
  - itr_ack/err/rty_o are 0;
  - itr_stall_o is all 1s.
- Owner active condition: itr_cyc_i[owner] | itr_lock_i[owner].
- Arbitration, evaluated combinationally every cycle. gnt_next is set as follows:
  - Owner exists and is active: gnt_next = gnt_reg.
  - Otherwise: search itr_cyc_i starting at ptr_reg, wrapping modulo N_ITR. The first asserted bit wins. If none is asserted, gnt_next=0.
- Every new grant to initiator k sets ptr_reg <= (k+1) mod N_ITR. A held grant does not move ptr_reg.
- Grant latency:
  - itr_cyc_i[k] rising at edge n with the bus free gives gnt_reg[k]=1 after edge n+1, and tgt_cyc_o=1 in that cycle.
  - Handover: owner deasserts CYC and LOCK in cycle m, so tgt_cyc_o=0 in cycle m. The new owner drives the bus from cycle m+1, with no idle gap beyond cycle m.
- Request mux, gated by gnt_reg:
  - tgt_cyc_o = itr_cyc_i[owner]; tgt_stb_o = itr_stb_i[owner]; the other request signals are sliced from the owner.
  - tgt_lock_o = itr_lock_i[owner] & itr_cyc_i[owner].
- Response demux:
  - itr_ack/err/rty_o[owner] = tgt_*_i. Non-owners get 0.
  - itr_stall_o[owner] = tgt_stall_i. Non-owners get 1.
  - itr_dat_o = tgt_dat_i unconditionally.
- Responses arriving while gnt_reg=0 (stray acks) are dropped.
- No combinational path from any itr_cyc_i to gnt_o. The only combinational paths through the block are the request mux and the response demux.
- Lock: owner holds LOCK with CYC low between cycles, so the grant is retained and tgt_cyc_o=0. Other requesters stay stalled until LOCK drops.
- Abort: owner drops CYC with acks outstanding. The grant is released per the rule above; late acks go to the new owner. The target must tolerate CYC negation, per the Wishbone abort rule.
- sync_rst_i or async_rst_i mid-cycle: gnt_reg and ptr_reg return to reset values (sync_rst_i at the next edge), so tgt_cyc_o=0 immediately after.
- N_ITR=1 degenerates to a registered pass-through grant. The pointer stays 0.

Test Plan:
1. Reset with itr_cyc_i=4'b1111 held through reset → gnt_o=0, tgt_cyc_o=0, itr_stall_o=4'b1111 during reset. After release: gnt_o=4'b0001 one cycle later, ptr=1.
2. All four initiators request continuously, each doing 1-access cycles (CYC dropped after ack) → grants rotate 0,1,2,3,0 with no cycle where two gnt_o bits are set.
3. Initiator 2 issues a pipelined burst of 3 STBs at adr 0x0010..0x0012 under tgt_stall_i=1 for 2 cycles → tgt_adr_o follows initiator 2 only. itr_ack_o[2] pulses 3 times; itr_ack_o[0,1,3] stay 0.
4. Initiator 1 holds LOCK=1 while dropping CYC for 3 cycles, with initiator 3 requesting → gnt_o stays 4'b0010 and itr_stall_o[3]=1. Initiator 3 is granted the cycle after LOCK drops.
5. Owner 0 aborts (CYC→0) with 1 ack outstanding while initiator 1 waits → gnt_o=4'b0010 next cycle. The late tgt_ack_i goes to itr_ack_o[1]. tgt_err_i asserted while gnt_o=0 reaches no output.
6. sync_rst_i pulsed mid-burst of owner 3 → gnt_o=0 and tgt_cyc_o=0 after the edge. Arbitration restarts from ptr=0.
